// File: rtl/vga_c.sv
// vga_c: shared VGA geometry constants, count widths and timing flag struct
package vga_c;
  localparam int H_VIS = 640;
  localparam int H_FP = 16;
  localparam int H_SP = 96;
  localparam int H_BP = 48;
  localparam int V_VIS = 480;
  localparam int V_FP = 10;
  localparam int V_SP = 2;
  localparam int V_BP = 33;
  localparam int W = H_VIS + H_FP + H_SP + H_BP - 1;
  localparam int H = V_VIS + V_FP + V_SP + V_BP - 1;
  localparam int CX = 10;
  localparam int CY = 10;
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic line_start;
    logic frame_start;
  } vga_tim_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: counts from the h/v counter stage and timing outputs to the pixel/DAC side
// master = counter/sink side (drives counts), slave = timing generator
interface vga_timing_gen_if import vga_c::*; #(parameter int FC_W = 8);
  logic [CX-1:0] h_count;
  logic [CY-1:0] v_count;
  logic hsync;
  logic vsync;
  logic de;
  logic [CX-1:0] px_x;
  logic [CY-1:0] px_y;
  logic line_start;
  logic frame_start;
  logic [FC_W-1:0] frame_cnt;
  logic seq_err;
  modport master (
    output h_count, v_count,
    input hsync, vsync, de, px_x, px_y, line_start, frame_start, frame_cnt, seq_err
  );
  modport slave (
    input h_count, v_count,
    output hsync, vsync, de, px_x, px_y, line_start, frame_start, frame_cnt, seq_err
  );
endinterface

// File: rtl/vga_seq_check.sv
// vga_seq_check: sticky flag for h/v counts that skip, stall, wrap wrongly or exceed W/H
// ports: clk, rst (async active-low), h/v sampled counts, err sticky error
module vga_seq_check import vga_c::*; #(
  parameter int W_MAX = W,
  parameter int H_MAX = H
) (
  input  logic clk,
  input  logic rst,
  input  logic [CX-1:0] h,
  input  logic [CY-1:0] v,
  output logic err
);
  localparam logic [CX-1:0] WX = CX'(W_MAX);
  localparam logic [CY-1:0] HX = CY'(H_MAX);
  logic armed;
  logic [CX-1:0] ph, eh;
  logic [CY-1:0] pv, ev;
  logic bad;
  always_comb begin
    eh = (ph == WX) ? '0 : ph + 1'b1;
    ev = (ph == WX) ? ((pv == HX) ? '0 : pv + 1'b1) : pv;
    bad = (h > WX) || (v > HX) || (armed && (h != eh || v != ev));
  end
  // the first sample after reset only seeds the reference, so any resume point is accepted
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      armed <= 1'b0;
      ph <= '0;
      pv <= '0;
      err <= 1'b0;
    end else begin
      armed <= 1'b1;
      ph <= h;
      pv <= v;
      if (bad) err <= 1'b1;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-stage registered hsync/vsync/de/pixel coords/strobes/frame count from h/v counts
// ports: clk, rst (async active-low), bus (slave: h_count/v_count in, timing outputs out)
module vga_timing_gen import vga_c::*; #(
  parameter int H_VIS_P = H_VIS,
  parameter int H_FP_P = H_FP,
  parameter int H_SP_P = H_SP,
  parameter int H_BP_P = H_BP,
  parameter int V_VIS_P = V_VIS,
  parameter int V_FP_P = V_FP,
  parameter int V_SP_P = V_SP,
  parameter int V_BP_P = V_BP,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int FC_W = 8
) (
  input logic clk,
  input logic rst,
  vga_timing_gen_if.slave bus
);
  localparam int WL = H_VIS_P + H_FP_P + H_SP_P + H_BP_P - 1;
  localparam int HL = V_VIS_P + V_FP_P + V_SP_P + V_BP_P - 1;
  localparam logic [CX-1:0] HV = CX'(H_VIS_P);
  localparam logic [CX-1:0] HS0 = CX'(H_VIS_P + H_FP_P);
  localparam logic [CX-1:0] HS1 = CX'(H_VIS_P + H_FP_P + H_SP_P);
  localparam logic [CY-1:0] VV = CY'(V_VIS_P);
  localparam logic [CY-1:0] VS0 = CY'(V_VIS_P + V_FP_P);
  localparam logic [CY-1:0] VS1 = CY'(V_VIS_P + V_FP_P + V_SP_P);
  vga_tim_t dec, t1, tim;
  logic val1;
  logic [CX-1:0] h1, px_x;
  logic [CY-1:0] v1, px_y;
  logic [FC_W-1:0] fc;
  logic chk_err, err;
  // stage-1 flags hold active-high sync decisions; polarity is applied in stage 2
  always_comb begin
    dec = '0;
    dec.hsync = (bus.h_count >= HS0) && (bus.h_count < HS1);
    dec.vsync = (bus.v_count >= VS0) && (bus.v_count < VS1);
    dec.de = (bus.h_count < HV) && (bus.v_count < VV);
    dec.line_start = bus.h_count == '0;
    dec.frame_start = (bus.h_count == '0) && (bus.v_count == '0);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      val1 <= 1'b0;
      h1 <= '0;
      v1 <= '0;
      t1 <= '0;
    end else begin
      val1 <= 1'b1;
      h1 <= bus.h_count;
      v1 <= bus.v_count;
      t1 <= dec;
    end
  // nothing but reset values leaves stage 2 until a real sample occupies stage 1
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tim <= '{hsync: ~HS_POL, vsync: ~VS_POL, default: 1'b0};
      px_x <= '0;
      px_y <= '0;
      fc <= '0;
      err <= 1'b0;
    end else if (val1) begin
      tim <= '{hsync: t1.hsync ? HS_POL : ~HS_POL,
               vsync: t1.vsync ? VS_POL : ~VS_POL,
               de: t1.de,
               line_start: t1.line_start,
               frame_start: t1.frame_start};
      if (t1.de) begin
        px_x <= h1;
        px_y <= v1;
      end
      fc <= fc + FC_W'(t1.frame_start);
      err <= chk_err;
    end
  vga_seq_check #(.W_MAX(WL), .H_MAX(HL)) u_chk (
    .clk(clk),
    .rst(rst),
    .h(bus.h_count),
    .v(bus.v_count),
    .err(chk_err)
  );
  assign bus.hsync = tim.hsync;
  assign bus.vsync = tim.vsync;
  assign bus.de = tim.de;
  assign bus.line_start = tim.line_start;
  assign bus.frame_start = tim.frame_start;
  assign bus.px_x = px_x;
  assign bus.px_y = px_y;
  assign bus.frame_cnt = fc;
  assign bus.seq_err = err;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a shrunken 25x11 raster
module tb_vga_timing_gen;
  localparam int HVIS = 16, HFP = 2, HSP = 4, HBP = 3;
  localparam int VVIS = 6, VFP = 1, VSP = 2, VBP = 2;
  localparam int W = HVIS + HFP + HSP + HBP - 1;
  localparam int H = VVIS + VFP + VSP + VBP - 1;
  localparam logic [33:0] RST = {5'b11000, 10'd0, 10'd0, 8'd0, 1'b0};
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0, n_fail = 0;
  int ch = 0, cv = 0;
  string phase = "reset";
  logic [33:0] q[$];
  int m_ph, m_pv;
  logic m_armed, m_err;
  logic [9:0] m_px, m_py;
  logic [7:0] m_fc;
  vga_timing_gen_if #(.FC_W(8)) bus();
  vga_timing_gen #(
    .H_VIS_P(HVIS), .H_FP_P(HFP), .H_SP_P(HSP), .H_BP_P(HBP),
    .V_VIS_P(VVIS), .V_FP_P(VFP), .V_SP_P(VSP), .V_BP_P(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .FC_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [33:0] obs();
    return {bus.hsync, bus.vsync, bus.de, bus.line_start, bus.frame_start,
            bus.px_x, bus.px_y, bus.frame_cnt, bus.seq_err};
  endfunction
  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h (hs,vs,de,ls,fs|x|y|fc|err)", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    m_armed = 1'b0;
    m_err = 1'b0;
    m_ph = 0;
    m_pv = 0;
    m_px = '0;
    m_py = '0;
    m_fc = '0;
    q.delete();
    q.push_back(RST);
    q.push_back(RST);
  endtask
  task automatic drive(input int h, input int v);
    int eh, ev;
    logic bad, de, fs, hs, vs;
    bus.h_count = 10'(h);
    bus.v_count = 10'(v);
    eh = (m_ph == W) ? 0 : m_ph + 1;
    ev = (m_ph == W) ? ((m_pv == H) ? 0 : m_pv + 1) : m_pv;
    bad = h > W || v > H || (m_armed && (h != eh || v != ev));
    m_err = m_err | bad;
    m_armed = 1'b1;
    m_ph = h;
    m_pv = v;
    de = h < HVIS && v < VVIS;
    if (de) begin
      m_px = 10'(h);
      m_py = 10'(v);
    end
    fs = h == 0 && v == 0;
    if (fs) m_fc = m_fc + 8'd1;
    hs = !(h >= HVIS + HFP && h < HVIS + HFP + HSP);
    vs = !(v >= VVIS + VFP && v < VVIS + VFP + VSP);
    q.push_back({hs, vs, de, logic'(h == 0), fs, m_px, m_py, m_fc, m_err});
  endtask
  task automatic cmp_drive(input int h, input int v);
    if (q.size() >= 2) chk(phase, obs(), q.pop_front());
    drive(h, v);
  endtask
  task automatic adv();
    if (ch == W) begin
      ch = 0;
      cv = (cv == H) ? 0 : cv + 1;
    end else ch++;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmp_drive(ch, cv);
      adv();
    end
  endtask
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cmp_drive(ch, cv);
    adv();
  endtask
  initial begin
    bus.h_count = '0;
    bus.v_count = '0;
    repeat (3) @(negedge clk);
    chk("reset", obs(), RST);
    ch = 0;
    cv = 0;
    phase = "frame";
    release_rst();
    run((W + 1) * (H + 1) + 5);
    phase = "fc_wrap";
    ch = 0;
    cv = 0;
    run(256 * (W + 1) * (H + 1));
    phase = "skip";
    while (!(ch == 11 && cv == 2)) run(1);
    ch = 12;
    run(3 * (W + 1) * (H + 1));
    phase = "mid_rst";
    while (ch != 12) run(1);
    #2 rst = 1'b0;
    #1 chk("async_rst", obs(), RST);
    ch = 0;
    cv = 4;
    phase = "resume";
    release_rst();
    run(2 * (W + 1) * (H + 1));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Sits directly downstream of the VGA h/v counter stage and consumes its h_count/v_count.
- Produces registered hsync, vsync, display-enable (de), pixel coordinates, line/frame strobes and a frame counter for the pixel/colour stage and the DAC pins.
- Includes a sequence checker that flags a counter that skips, stalls or wraps at the wrong value.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SP, 96, horizontal sync pulse width (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SP, 2, vertical sync pulse width (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- FC_W, 8, frame counter width

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- h_count  in  CX  horizontal count; runs 0..W, then wraps to 0
- v_count  in  CY  vertical count; advances when h_count wraps, runs 0..H, then wraps to 0
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  high in visible region
- px_x  out  CX  pixel x, valid when de=1
- px_y  out  CY  pixel y, valid when de=1
- line_start  out  1  one-cycle pulse, aligned with h_count==0 of every line
- frame_start  out  1  one-cycle pulse, aligned with h_count==0 and v_count==0
- frame_cnt  out  FC_W  frames started since reset; wraps modulo 2^FC_W
- seq_err  out  1  sticky counter-sequence error flag

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - hsync = ~HS_POL and vsync = ~VS_POL (inactive levels)
  - de, line_start, frame_start, seq_err = 0
  - px_x, px_y, frame_cnt = 0
  - checker disarmed and pipeline valid bits = 0
- Pipeline and latency: 2 cycles from an input sample to its outputs.
  - Stage 1 registers the counts and the region compares.
  - Stage 2 registers the final outputs.
  - All outputs are registered; no combinational path from input to output.
- Region decode, on the stage-1 sample:
  - de = (h < H_VIS) && (v < V_VIS)
  - hs_act = (h >= H_VIS+H_FP) && (h < H_VIS+H_FP+H_SP)
  - vs_act = (v >= V_VIS+V_FP) && (v < V_VIS+V_FP+V_SP); vsync transitions align with the h==0 sample
  - hsync = hs_act ? HS_POL : ~HS_POL; vsync likewise with VS_POL
- px_x = h and px_y = v when de=1; otherwise both hold their last visible value.
- line_start = (h==0); frame_start = (h==0 && v==0).
- frame_cnt increments in the same cycle that frame_start is output high.
- Valid gating: outputs stay at their reset values until the first sample has propagated, i.e. 2 cycles after rst deasserts.
- Sequence checker:
  - Arms on the first post-reset sample and compares each sample against the previous one.
  - Expected h: prev_h==W ? 0 : prev_h+1.
  - Expected v: if prev_h==W then (prev_v==H ? 0 : prev_v+1), else prev_v.
  - Any mismatch, or h>W, or v>H, sets seq_err on the next cycle.
  - seq_err clears only on reset; timing outputs keep tracking the inputs after an error.
- Boundary conditions:
  - h==W with v==H: next sample (0,0) raises both frame_start and line_start.
  - frame_cnt wraps 2^FC_W-1 → 0 with no error.
- Reset mid-frame: outputs go to reset values immediately; the checker re-arms, so a resumed count at any value is accepted as the new reference.

Decomposition:
- Package vga_c already holds CX, CY, W, H.
- Add to vga_c: the timing constants H_VIS/H_FP/H_SP/V_VIS/V_FP/V_SP, with W = H_VIS+H_FP+H_SP+H_BP-1 (H_BP=48) and H = V_VIS+V_FP+V_SP+V_BP-1 (V_BP=33).
- Add a packed struct vga_tim_t {hsync, vsync, de, line_start, frame_start}.
- One natural sub-module: vga_seq_check (checker plus armed flag), instantiated once.

Test Plan:
- Reset then a clean counter for one frame (800×525 cycles) → de high for exactly 640 cycles/line on 480 lines; hsync low for 96 cycles starting 2 cycles after h_count=656; seq_err=0.
- Sample h=0, v=0 → frame_start and line_start high exactly 2 cycles later; frame_cnt 0→1.
- Lines v=490,491 → vsync low across both; high again 2 cycles after (h=0, v=492).
- Inject skip h=100→102 → seq_err=1 at the 2nd cycle after the bad sample; stays 1 for the rest of the run.
- Run 256 frames with FC_W=8 → frame_cnt wraps 255→0, seq_err=0.
- Assert rst mid-line at h=300 → all outputs reset asynchronously; counter resumes at h=0, v=200 → no seq_err, de high 2 cycles later with px_x=0, px_y=200.
